lsu_mem_ctrl: RTL and testbench

- Load/store initiator between the execute stage and the data memory.
- Decodes RV32I load/store width (funct3); the data memory is read combinationally and written as a full word on the clock edge.
- Performs sign/zero extension for loads.
- Performs read-modify-write for SB/SH, because the memory only writes whole big-endian words.
- Flags misaligned accesses without touching memory.

---
 rtl/lsu_mem_ctrl_pkg.sv | 25 ++
 rtl/lsu_lane_align.sv | 28 ++
 rtl/lsu_mem_ctrl.sv | 105 ++++++++++
 tb/tb_lsu_mem_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg: shared widths, funct3 encodings, FSM states and the alignment check for the LSU.
package lsu_mem_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int DATA_ADDR = 14;
  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_f3_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } lsu_state_e;
  // Illegal funct3 (011, 11x) or an offset the access width cannot start at.
  function automatic logic lsu_bad(input logic [2:0] f3, input logic [1:0] off);
    return (f3 == 3'b011 || f3[2:1] == 2'b11) ? 1'b1 :
           (f3[1:0] == LSU_W[1:0]) ? |off :
           f3[0] ? off[0] : 1'b0;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: big-endian lane extraction with sign/zero extension for loads,
// and byte/halfword merge into an old word for sub-word stores.
module lsu_lane_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      f3,
  input  logic [15:0]     wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged
);
  logic [4:0]      bits;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] ins;
  logic            sx;
  always_comb begin
    bits      = {off, 3'b000};
    sh        = word << bits;
    sx        = ~f3[2] & sh[XLEN-1];
    load_data = f3[1] ? word :
                f3[0] ? {{16{sx}}, sh[31:16]} : {{24{sx}}, sh[31:24]};
    mask      = (f3[0] ? 32'hFFFF_0000 : 32'hFF00_0000) >> bits;
    ins       = f3[0] ? {wdata, 16'h0} : {wdata[7:0], 24'h0};
    merged    = (word & ~mask) | (ins >> bits);
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between execute and a combinational-read,
// whole-word-write data memory; sub-word stores go through read-modify-write.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);
  lsu_state_e      state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] merge_q, merge_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged;

  lsu_lane_align u_align (
    .word      (mem_rdata),
    .off       (addr_q[1:0]),
    .f3        (f3_q),
    .wdata     (wdata_q[15:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = lsu_bad(req_funct3, req_addr[1:0]);
        state_d = err_d ? S_RESP :
                  !req_store ? S_LOAD :
                  (req_funct3[1:0] == LSU_W[1:0]) ? S_WRITE : S_RMW_RD;
      end
      S_LOAD: begin
        rdata_d = load_data;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        merge_d = merged;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = resp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Write data is forced to zero outside WRITE so nothing stale reaches the bus.
  always_comb begin
    req_ready  = state_q == S_IDLE;
    resp_valid = state_q == S_RESP;
    resp_rdata = rdata_q;
    resp_err   = err_q;
    mem_addr   = {addr_q[XLEN-1:2], 2'b00};
    mem_we     = state_q == S_WRITE;
    mem_wdata  = mem_we ? ((f3_q[1:0] == LSU_W[1:0]) ? wdata_q : merge_q) : '0;
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: table-driven scoreboard bench for lsu_mem_ctrl against a
// big-endian word memory model, plus back-pressure and mid-RMW reset sequences.
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [4096];
  int          we_cnt = 0;
  int          pass_cnt = 0;
  int          total = 0;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
    logic [31:0] waddr;
    logic [31:0] wword;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  lsu_mem_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[13:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[13:2]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                              input int lat, input int nwe, input logic [31:0] waddr,
                              input logic [31:0] wword);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
    v.lat = lat; v.nwe = nwe; v.waddr = waddr; v.wword = wword;
    return v;
  endfunction

  // hold: cycles resp_ready stays low after resp_valid, with a competing request offered meanwhile.
  task automatic run(input vec_t v, input int hold);
    vec_t        e;
    int          lat;
    int          nwe;
    int          we_lat;
    logic [31:0] wa;
    logic [31:0] ww;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = v.st; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    sb.push_back(v);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nwe = 0; we_lat = 0; wa = '0; ww = '0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_we) begin nwe++; we_lat = lat; wa = mem_addr; ww = mem_wdata; end
    end while (!resp_valid && lat < 20);
    e = sb.pop_front();
    chk($sformatf("latency@%h", e.addr), 32'(lat), 32'(e.lat));
    chk($sformatf("rdata@%h", e.addr), resp_rdata, e.rdata);
    chk($sformatf("err@%h", e.addr), {31'b0, resp_err}, {31'b0, e.err});
    chk($sformatf("we_pulses@%h", e.addr), 32'(nwe), 32'(e.nwe));
    if (e.nwe > 0) begin
      chk("we_cycle", 32'(we_lat), 32'(e.lat - 1));
      chk("we_addr", wa, e.waddr);
      chk("we_word", ww, e.wword);
    end
    if (hold > 0) begin
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, e.rdata);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("resp_drop", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    int we_before;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[4] = 32'h8899_AABB;
    mem[12] = 32'h1122_3344;
    tbl.push_back(mk(0, 3'b000, 32'h10, 0, 32'hFFFF_FF88, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 3'b100, 32'h11, 0, 32'h0000_0099, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 32'h12, 0, 32'hFFFF_AABB, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 3'b101, 32'h10, 0, 32'h0000_8899, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 3'b000, 32'h11, 32'h1234_5655, 0, 0, 3, 1, 32'h10, 32'h8855_AABB));
    tbl.push_back(mk(0, 3'b010, 32'h10, 0, 32'h8855_AABB, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h12, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 3'b001, 32'h13, 32'hFFFF_FFFF, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'b011, 32'h10, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h10, 0, 32'h8855_AABB, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 32'h13, 0, 32'hFFFF_FFBB, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 3'b001, 32'h12, 32'h0000_7E01, 0, 0, 3, 1, 32'h10, 32'h8855_7E01));
    tbl.push_back(mk(0, 3'b001, 32'h12, 0, 32'h0000_7E01, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 3'b100, 32'h12, 0, 32'h0000_007E, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 3'b110, 32'h10, 32'h0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h10, 0, 32'h8855_7E01, 0, 2, 0, 0, 0));

    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run(tbl[i], 0);

    run(mk(1, 3'b010, 32'h20, 32'hDEAD_BEEF, 0, 0, 2, 1, 32'h20, 32'hDEAD_BEEF), 5);
    run(mk(0, 3'b010, 32'h20, 0, 32'hDEAD_BEEF, 0, 2, 0, 0, 0), 0);

    // Reset lands while the SB sits in RMW_RD; the write must never happen.
    we_before = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h30; req_wdata = 32'hAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("arst_resp_rdata", resp_rdata, 32'd0);
    chk("arst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("arst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("arst_mem_wdata", mem_wdata, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_word", mem[12], 32'h1122_3344);
    chk("post_rst_we_cnt", 32'(we_cnt), 32'(we_before));
    run(mk(0, 3'b010, 32'h30, 0, 32'h1122_3344, 0, 2, 0, 0, 0), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
